// File: rtl/ntt_mem_ctrl.sv
// ntt_mem_ctrl: memory-side initiator for the NTT/INTT coefficient RAM.
// Steps through the butterfly schedule one butterfly at a time. Each one
// reads a coefficient pair, hands it with the zeta index to an external
// butterfly unit, and writes both results back to the same two addresses.
module ntt_mem_ctrl #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              mode_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] ram_addr1_o,
  output logic [ADDR_W-1:0] ram_addr2_o,
  output logic              ram_wren_o,
  output logic [DATA_W-1:0] ram_wdata1_o,
  output logic [DATA_W-1:0] ram_wdata2_o,
  input  logic [DATA_W-1:0] ram_rdata1_i,
  input  logic [DATA_W-1:0] ram_rdata2_i,
  output logic              bf_valid_o,
  output logic [DATA_W-1:0] bf_a_o,
  output logic [DATA_W-1:0] bf_b_o,
  output logic [7:0]        bf_zeta_idx_o,
  output logic              bf_mode_o,
  input  logic              bf_done_i,
  input  logic [DATA_W-1:0] bf_a_i,
  input  logic [DATA_W-1:0] bf_b_i
);

  localparam int N = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LEN_MAX = ADDR_W'(N/2);
  localparam logic [ADDR_W-1:0] LEN_MIN = ADDR_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_LD, S_WAIT, S_WR, S_DONE} state_t;

  state_t            state_q;
  logic              mode_q;
  logic [ADDR_W-1:0] j_q, len_q;
  logic [7:0]        k_q;

  logic              busy_q, done_q, wren_q, bf_valid_q;
  logic [ADDR_W-1:0] addr1_q, addr2_q;
  logic [DATA_W-1:0] wdata1_q, wdata2_q, bf_a_q, bf_b_q;
  logic [7:0]        zeta_q;

  logic [ADDR_W:0]   jn;
  logic [ADDR_W-1:0] j_d, len_d;
  logic [7:0]        k_d;
  logic              last_d;

  // Next butterfly indices: step j, skip the partner half at a group end, wrap at a layer end.
  always_comb begin
    jn     = {1'b0, j_q} + 1'b1;
    k_d    = k_q;
    len_d  = len_q;
    last_d = 1'b0;
    if ((jn[ADDR_W-1:0] & (len_q - 1'b1)) == '0) begin
      jn  = jn + {1'b0, len_q};
      k_d = mode_q ? (k_q - 8'd1) : (k_q + 8'd1);
    end
    j_d = jn[ADDR_W-1:0];
    if (jn[ADDR_W]) begin
      j_d    = '0;
      len_d  = mode_q ? (len_q << 1) : (len_q >> 1);
      last_d = mode_q ? (len_q == LEN_MAX) : (len_q == LEN_MIN);
    end
  end

  // Control FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      j_q        <= '0;
      len_q      <= '0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wren_q     <= 1'b0;
      bf_valid_q <= 1'b0;
      addr1_q    <= '0;
      addr2_q    <= '0;
      wdata1_q   <= '0;
      wdata2_q   <= '0;
      bf_a_q     <= '0;
      bf_b_q     <= '0;
      zeta_q     <= '0;
    end else begin
      done_q     <= 1'b0;
      wren_q     <= 1'b0;
      bf_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            mode_q  <= mode_i;
            j_q     <= '0;
            len_q   <= mode_i ? LEN_MIN : LEN_MAX;
            k_q     <= mode_i ? 8'd255 : 8'd1;
            addr1_q <= '0;
            addr2_q <= mode_i ? LEN_MIN : LEN_MAX;
            busy_q  <= 1'b1;
            state_q <= S_RD;
          end
        end
        S_RD: begin
          bf_valid_q <= 1'b1;
          zeta_q     <= k_q;
          state_q    <= S_LD;
        end
        S_LD: begin
          bf_a_q  <= ram_rdata1_i;
          bf_b_q  <= ram_rdata2_i;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bf_done_i) begin
            wdata1_q <= bf_a_i;
            wdata2_q <= bf_b_i;
            wren_q   <= 1'b1;
            state_q  <= S_WR;
          end
        end
        S_WR: begin
          j_q   <= j_d;
          len_q <= len_d;
          k_q   <= k_d;
          if (last_d) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            addr1_q <= j_d;
            addr2_q <= j_d + len_d;
            state_q <= S_RD;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign ram_addr1_o   = addr1_q;
  assign ram_addr2_o   = addr2_q;
  assign ram_wren_o    = wren_q;
  assign ram_wdata1_o  = wdata1_q;
  assign ram_wdata2_o  = wdata2_q;
  assign bf_valid_o    = bf_valid_q;
  assign bf_zeta_idx_o = zeta_q;
  assign bf_mode_o     = mode_q;
  // The RAM output register already delays read data into LD, so it is passed
  // straight through in LD and held from the capture register afterwards.
  assign bf_a_o        = (state_q == S_LD) ? ram_rdata1_i : bf_a_q;
  assign bf_b_o        = (state_q == S_LD) ? ram_rdata2_i : bf_b_q;

endmodule

// File: doc/ntt_mem_ctrl.md
Name: ntt_mem_ctrl

Overview:
Memory-side initiator for the 256 x 24-bit dual-port coefficient RAM. Walks the Dilithium NTT/INTT butterfly schedule, one butterfly at a time:
- issues the paired read addresses,
- hands the two coefficients and the zeta index to an external butterfly unit,
- writes the two results back to the same addresses.
It is the only master of the RAM address, write-enable and write-data lines while busy.

Parameters:
DATA_W, 24, coefficient width on RAM and butterfly buses
ADDR_W, 8, RAM address width; N = 2**ADDR_W = 256 coefficients, ADDR_W layers

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  start request, sampled in IDLE only
mode_i  in  1  0 = forward NTT, 1 = inverse NTT; latched on accepted start
busy_o  out  1  high from the cycle after start is accepted through the DONE cycle
done_o  out  1  one-cycle pulse in the DONE state
ram_addr1_o  out  ADDR_W  RAM port 1 address (lower index j)
ram_addr2_o  out  ADDR_W  RAM port 2 address (j+len)
ram_wren_o  out  1  RAM write enable
ram_wdata1_o  out  DATA_W  write data for addr1
ram_wdata2_o  out  DATA_W  write data for addr2
ram_rdata1_i  in  DATA_W  RAM read data 1; valid the cycle after the address is presented
ram_rdata2_i  in  DATA_W  RAM read data 2
bf_valid_o  out  1  one-cycle pulse: bf_a_o, bf_b_o and bf_zeta_idx_o are valid
bf_a_o  out  DATA_W  coefficient at j
bf_b_o  out  DATA_W  coefficient at j+len
bf_zeta_idx_o  out  8  zeta table index k
bf_mode_o  out  1  latched mode, for zeta sign and butterfly type
bf_done_i  in  1  butterfly results valid; sampled in WAIT only
bf_a_i  in  DATA_W  result for j
bf_b_i  in  DATA_W  result for j+len

Behaviour:
- Reset state: IDLE.
- Reset values: all outputs 0, including the address, wdata, bf_* and flag outputs.
- Reset asserted mid-run returns to IDLE immediately; ram_wren_o drops asynchronously. No partial completion is reported.
- FSM states: IDLE, RD, LD, WAIT, WR, DONE.
  - IDLE: on start_i=1, latch mode, initialise indices, go to RD.
  - RD: drive ram_addr1_o=j and ram_addr2_o=j+len; ram_wren_o=0. Go to LD.
  - LD: bf_a_o/bf_b_o = registered ram_rdata1_i/ram_rdata2_i; bf_valid_o=1; bf_zeta_idx_o=k. Go to WAIT.
  - WAIT: stay until bf_done_i=1. Then latch bf_a_i/bf_b_i into ram_wdata1_o/ram_wdata2_o and go to WR.
  - WR: same addresses as RD; ram_wren_o=1 for exactly this cycle. Advance indices. Go to RD, or to DONE after the last butterfly.
  - DONE: done_o=1 for one cycle, then IDLE.
- Addresses hold their last value outside RD/WR. The RAM writes on the falling edge inside the WR cycle.
- bf_done_i seen outside WAIT is ignored. start_i while busy is ignored.
- Index advance after WR:
  - jn = j+1.
  - If (jn & (len-1)) == 0, the group ends: jn += len and k steps.
  - If jn reaches N, the layer ends: j=0 and len shifts.
  - Forward: len starts at 128 and halves each layer (128..1). k starts at 1 and increments per group, ending at 255.
  - Inverse: len starts at 1 and doubles each layer (1..128). k starts at 255 and decrements per group, ending at 1.
- Counts: 128 butterflies per layer, 1024 in total.
- Timing, with bf_done_i arriving one cycle after bf_valid_o:
  - Start accepted at cycle 0.
  - Butterfly b: RD at cycle 1+4b, WR at cycle 4+4b.
  - done_o at cycle 4097.

Test Plan:
- Reset: assert rst_i mid-cycle -> all outputs 0 asynchronously, state IDLE, busy_o=0.
- Forward NTT, bf_done_i one cycle after bf_valid_o:
  - butterfly 0 reads (0,128) with k=1; butterfly 1 reads (1,129) with k=1;
  - butterfly 128 reads (0,64) with k=2; butterfly 192 reads (128,192) with k=3;
  - butterfly 1023 reads (254,255) with k=255; done_o pulses at cycle 4097.
- Inverse NTT: butterfly 0 reads (0,1) with k=255; butterfly 1 reads (2,3) with k=254; butterfly 1023 reads (127,255) with k=1.
- Writeback:
  - RAM model returns 0x000111/0x000222 -> bf_a_o/bf_b_o show those values in LD.
  - Bench returns bf_a_i=0xABCDEF, bf_b_i=0x123456 -> one ram_wren_o pulse in WR, same addresses as RD, wdata matches.
- Stall: delay bf_done_i by 5 cycles -> FSM stays in WAIT, ram_wren_o stays 0, the butterfly takes 9 cycles; a spurious bf_done_i in RD is ignored.
- Control:
  - start_i pulses while busy -> no effect.
  - rst_i at butterfly 300, then restart -> sequence restarts at (0,128) with k=1 and no done_o from the aborted run.
